// File: rtl/push_sw_multi_debounce_if.sv
// Bundle of button-side and event-side signals for the multi-channel debouncer.
// No valid/ready handshake: i_btn is an asynchronous level and every o_* signal is
// a registered level or one-cycle strobe, sampled on any rising i_clk edge.
interface push_sw_multi_debounce_if #(
   parameter int N_CH   = 4,
   parameter int PCNT_W = 8
);
   logic [N_CH-1:0]        i_btn;
   logic                   i_clr_cnt;
   logic [N_CH-1:0]        o_level;
   logic [N_CH-1:0]        o_press;
   logic [N_CH-1:0]        o_release;
   logic [N_CH-1:0]        o_long;
   logic [N_CH*PCNT_W-1:0] o_press_cnt;

   modport master (
      output i_btn, i_clr_cnt,
      input  o_level, o_press, o_release, o_long, o_press_cnt
   );

   modport slave (
      input  i_btn, i_clr_cnt,
      output o_level, o_press, o_release, o_long, o_press_cnt
   );
endinterface

// File: rtl/push_sw_multi_debounce.sv
// N-channel push-button conditioner: 2-flop synchroniser, polarity normalise,
// debounce, press/release/long-press strobes and a wrapping press counter per channel.
module push_sw_multi_debounce #(
   parameter int N_CH       = 4,
   parameter int CNT_LEN    = 20,
   parameter int DB_CYC     = 480000,
   parameter int LONG_CYC   = 960000,
   parameter int ACTIVE_LOW = 1,
   parameter int PCNT_W     = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   push_sw_multi_debounce_if.slave  bus
);

   // Idle pin level; synchroniser resets here so reset release never looks like a press.
   localparam logic [N_CH-1:0]    IDLE      = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [CNT_LEN-1:0] DB_LAST   = CNT_LEN'(DB_CYC - 1);
   localparam logic [CNT_LEN-1:0] LONG_LAST = CNT_LEN'(LONG_CYC);
   localparam logic [CNT_LEN-1:0] LONG_PRE  = CNT_LEN'(LONG_CYC - 1);

   logic [N_CH-1:0]    r_sync1;
   logic [N_CH-1:0]    r_sync2;
   logic [N_CH-1:0]    r_level;
   logic [N_CH-1:0]    r_press;
   logic [N_CH-1:0]    r_release;
   logic [N_CH-1:0]    r_long;
   logic [CNT_LEN-1:0] r_db_cnt [N_CH];
   logic [CNT_LEN-1:0] r_lp_cnt [N_CH];
   logic [PCNT_W-1:0]  r_pcnt   [N_CH];

   logic [N_CH-1:0]        w_s;
   logic [N_CH-1:0]        w_flip;
   logic [N_CH*PCNT_W-1:0] w_pcnt_flat;

   // Normalised sample (1 = pressed) and the "accept the change this edge" condition.
   always_comb begin
      w_s    = r_sync2 ^ IDLE;
      w_flip = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_flip[k] = (w_s[k] != r_level[k]) && (r_db_cnt[k] == DB_LAST);
      end
   end

   // Two-flop synchroniser for the asynchronous pins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= IDLE;
         r_sync2 <= IDLE;
      end else begin
         r_sync1 <= bus.i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce, edge strobes and long-press timer; strobes rise together with the level change.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_long    <= '0;
         for (int k = 0; k < N_CH; k++) begin
            r_db_cnt[k] <= '0;
            r_lp_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            r_press[k]   <= 1'b0;
            r_release[k] <= 1'b0;
            r_long[k]    <= 1'b0;
            if (w_s[k] == r_level[k]) begin
               r_db_cnt[k] <= '0;
            end else if (w_flip[k]) begin
               r_level[k]   <= w_s[k];
               r_db_cnt[k]  <= '0;
               r_press[k]   <= w_s[k];
               r_release[k] <= ~w_s[k];
            end else begin
               r_db_cnt[k] <= r_db_cnt[k] + CNT_LEN'(1);
            end
            // A level change (press or release) restarts the timer; otherwise count up
            // while held and stop at LONG_CYC so o_long fires only once per press.
            if (w_flip[k]) begin
               r_lp_cnt[k] <= '0;
            end else if (r_level[k] && (r_lp_cnt[k] != LONG_LAST)) begin
               r_lp_cnt[k] <= r_lp_cnt[k] + CNT_LEN'(1);
               r_long[k]   <= (r_lp_cnt[k] == LONG_PRE);
            end
         end
      end
   end

   // Press counters: count the strobe one cycle after it shows, so a clear in the
   // same cycle as a press leaves that press counted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < N_CH; k++) begin
            r_pcnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (bus.i_clr_cnt) begin
               r_pcnt[k] <= PCNT_W'(r_press[k]);
            end else begin
               r_pcnt[k] <= r_pcnt[k] + PCNT_W'(r_press[k]);
            end
         end
      end
   end

   // Flatten per-channel counts onto the output bus.
   always_comb begin
      w_pcnt_flat = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_pcnt_flat[k*PCNT_W +: PCNT_W] = r_pcnt[k];
      end
   end

   assign bus.o_level     = r_level;
   assign bus.o_press     = r_press;
   assign bus.o_release   = r_release;
   assign bus.o_long      = r_long;
   assign bus.o_press_cnt = w_pcnt_flat;

endmodule

// File: tb/tb_push_sw_multi_debounce.sv
// Bench for push_sw_multi_debounce: table-driven level vectors, hand-written corner
// sequences, and an event scoreboard holding {cycle, press, release, long} per strobe cycle.
module tb_push_sw_multi_debounce;

   localparam int N_CH     = 4;
   localparam int CNT_LEN  = 8;
   localparam int DB_CYC   = 16;
   localparam int LONG_CYC = 64;
   localparam int PCNT_W   = 4;
   localparam int LAT      = DB_CYC + 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc   = 0;

   push_sw_multi_debounce_if #(.N_CH(N_CH), .PCNT_W(PCNT_W)) bus ();

   push_sw_multi_debounce #(
      .N_CH(N_CH), .CNT_LEN(CNT_LEN), .DB_CYC(DB_CYC),
      .LONG_CYC(LONG_CYC), .ACTIVE_LOW(1), .PCNT_W(PCNT_W)
   ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   // Clock and edge counter: after rising edge number n, cyc reads n.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N_CH-1:0] btn;
      logic [N_CH-1:0] exp_level;
   } vec_t;

   logic [43:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_cnt[N_CH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int unsigned c, input logic [3:0] p, input logic [3:0] r,
                          input logic [3:0] l);
      exp_q.push_back({c, p, r, l});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_press(input logic [N_CH-1:0] m);
      for (int k = 0; k < N_CH; k++) begin
         if (m[k]) exp_cnt[k] = (exp_cnt[k] + 1) % (1 << PCNT_W);
      end
   endtask

   task automatic clr_model();
      for (int k = 0; k < N_CH; k++) exp_cnt[k] = 0;
   endtask

   task automatic chk_cnts(input string tag);
      for (int k = 0; k < N_CH; k++) begin
         chk($sformatf("%s_cnt%0d", tag, k), 32'(bus.o_press_cnt[k*PCNT_W +: PCNT_W]),
             32'(exp_cnt[k]));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"}, 32'(bus.o_level), 32'd0);
      chk({tag, "_strobes"}, 32'({bus.o_press, bus.o_release, bus.o_long}), 32'd0);
      chk({tag, "_cnt"}, 32'(bus.o_press_cnt), 32'd0);
   endtask

   // Scoreboard: every cycle with a strobe must match the queue head for that cycle,
   // and a queued cycle with no strobe is reported as a mismatch.
   always @(negedge clk) begin
      logic [11:0] got;
      got = {bus.o_press, bus.o_release, bus.o_long};
      if (exp_q.size() > 0 && exp_q[0][43:12] == cyc) begin
         chk("strobes", 32'(got), 32'(exp_q[0][11:0]));
         void'(exp_q.pop_front());
      end else if (got != 12'd0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_strobe: got %h expected none (cycle %0d)", got, cyc);
      end
   end

   initial begin
      vec_t            vecs[10];
      logic [N_CH-1:0] prev;
      logic [N_CH-1:0] p;
      logic [N_CH-1:0] r;
      int unsigned     n;

      vecs[0] = '{4'b1110, 4'b0001};
      vecs[1] = '{4'b1111, 4'b0000};
      vecs[2] = '{4'b1100, 4'b0011};
      vecs[3] = '{4'b1111, 4'b0000};
      vecs[4] = '{4'b0101, 4'b1010};
      vecs[5] = '{4'b1111, 4'b0000};
      vecs[6] = '{4'b0000, 4'b1111};
      vecs[7] = '{4'b1111, 4'b0000};
      vecs[8] = '{4'b1011, 4'b0100};
      vecs[9] = '{4'b1111, 4'b0000};

      bus.i_btn     = '1;
      bus.i_clr_cnt = 1'b0;
      clr_model();

      // Reset with idle pins, then 200 quiet cycles.
      tick(3);
      chk_all_zero("in_reset");
      rst_n = 1'b1;
      tick(200);
      chk_all_zero("idle_200");

      // Table: each row held 40 cycles; changed channels strobe LAT edges after the pin edge.
      prev = '0;
      for (int i = 0; i < 10; i++) begin
         n         = cyc;
         bus.i_btn = vecs[i].btn;
         p         = vecs[i].exp_level & ~prev;
         r         = ~vecs[i].exp_level & prev;
         if ((p | r) != '0) push_ev(n + LAT, p, r, 4'b0000);
         count_press(p);
         tick(40);
         chk($sformatf("vec%0d_level", i), 32'(bus.o_level), 32'(vecs[i].exp_level));
         chk_cnts($sformatf("vec%0d", i));
         prev = vecs[i].exp_level;
      end

      // ch0 pressed 63 cycles: released just before the long-press point, no o_long.
      n = cyc;
      bus.i_btn[0] = 1'b0;
      push_ev(n + LAT, 4'b0001, 4'b0000, 4'b0000);
      push_ev(n + 63 + LAT, 4'b0000, 4'b0001, 4'b0000);
      count_press(4'b0001);
      tick(63);
      bus.i_btn[0] = 1'b1;
      tick(40);
      chk("ch0_63_level", 32'(bus.o_level), 32'd0);
      chk_cnts("ch0_63");

      // ch0 pressed 65 cycles: o_long exactly 64 cycles after o_press, then release.
      n = cyc;
      bus.i_btn[0] = 1'b0;
      push_ev(n + LAT, 4'b0001, 4'b0000, 4'b0000);
      push_ev(n + LAT + LONG_CYC, 4'b0000, 4'b0000, 4'b0001);
      push_ev(n + 65 + LAT, 4'b0000, 4'b0001, 4'b0000);
      count_press(4'b0001);
      tick(65);
      bus.i_btn[0] = 1'b1;
      tick(40);
      chk("ch0_65_level", 32'(bus.o_level), 32'd0);

      // ch1 bounces every 5 cycles: never stable long enough, nothing accepted.
      for (int i = 0; i < 12; i++) begin
         bus.i_btn[1] = ~bus.i_btn[1];
         tick(5);
      end
      bus.i_btn[1] = 1'b1;
      tick(40);
      chk("bounce_level", 32'(bus.o_level), 32'd0);
      chk_cnts("bounce");

      // ch2 held 200 cycles: one o_long 64 cycles after o_press, not repeated.
      n = cyc;
      bus.i_btn[2] = 1'b0;
      push_ev(n + LAT, 4'b0100, 4'b0000, 4'b0000);
      push_ev(n + LAT + LONG_CYC, 4'b0000, 4'b0000, 4'b0100);
      push_ev(n + 200 + LAT, 4'b0000, 4'b0100, 4'b0000);
      count_press(4'b0100);
      tick(100);
      chk("ch2_held_level", 32'(bus.o_level), 32'h4);
      tick(100);
      bus.i_btn[2] = 1'b1;
      tick(40);
      chk("ch2_rel_level", 32'(bus.o_level), 32'd0);
      chk_cnts("ch2_long");

      // Plain counter clear.
      bus.i_clr_cnt = 1'b1;
      tick(1);
      bus.i_clr_cnt = 1'b0;
      clr_model();
      tick(2);
      chk_cnts("clr");

      // 17 presses on ch3: 4-bit counter wraps to 1.
      for (int i = 0; i < 17; i++) begin
         n = cyc;
         bus.i_btn[3] = 1'b0;
         push_ev(n + LAT, 4'b1000, 4'b0000, 4'b0000);
         push_ev(n + 20 + LAT, 4'b0000, 4'b1000, 4'b0000);
         count_press(4'b1000);
         tick(20);
         bus.i_btn[3] = 1'b1;
         tick(25);
      end
      chk_cnts("wrap17");

      // 18th press with i_clr_cnt in the o_press cycle: ch3 keeps the press.
      n = cyc;
      bus.i_btn[3] = 1'b0;
      push_ev(n + LAT, 4'b1000, 4'b0000, 4'b0000);
      tick(LAT);
      bus.i_clr_cnt = 1'b1;
      tick(1);
      bus.i_clr_cnt = 1'b0;
      clr_model();
      count_press(4'b1000);
      tick(2);
      chk_cnts("clr_with_press");
      n = cyc;
      bus.i_btn[3] = 1'b1;
      push_ev(n + LAT, 4'b0000, 4'b1000, 4'b0000);
      tick(40);

      // ch0 and ch1 together: strobes share one cycle.
      n = cyc;
      bus.i_btn = 4'b1100;
      push_ev(n + LAT, 4'b0011, 4'b0000, 4'b0000);
      count_press(4'b0011);
      tick(30);
      chk("dual_level", 32'(bus.o_level), 32'h3);
      n = cyc;
      bus.i_btn = 4'b1111;
      push_ev(n + LAT, 4'b0000, 4'b0011, 4'b0000);
      tick(40);
      chk_cnts("dual");

      // Reset mid-debounce, pins released during reset: nothing afterwards.
      bus.i_btn = 4'b1100;
      tick(10);
      rst_n = 1'b0;
      clr_model();
      #1;
      chk_all_zero("rst_mid_db");
      bus.i_btn = 4'b1111;
      tick(3);
      rst_n = 1'b1;
      tick(100);
      chk_all_zero("after_rst_db");

      // Reset mid-long-press: no o_long or o_release afterwards.
      n = cyc;
      bus.i_btn[2] = 1'b0;
      push_ev(n + LAT, 4'b0100, 4'b0000, 4'b0000);
      tick(50);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid_long");
      bus.i_btn = 4'b1111;
      tick(3);
      rst_n = 1'b1;
      tick(100);
      chk_all_zero("after_rst_long");

      // ch3 held through reset: normal press after release, count 1.
      rst_n = 1'b0;
      bus.i_btn[3] = 1'b0;
      tick(5);
      rst_n = 1'b1;
      n = cyc;
      push_ev(n + LAT, 4'b1000, 4'b0000, 4'b0000);
      count_press(4'b1000);
      tick(30);
      chk("held_rst_level", 32'(bus.o_level), 32'h8);
      chk_cnts("held_rst");
      n = cyc;
      bus.i_btn = 4'b1111;
      push_ev(n + LAT, 4'b0000, 4'b1000, 4'b0000);
      tick(40);

      // Any queued event that never appeared is a failure.
      tick(5);
      while (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL pending_event: got none expected %h", exp_q[0]);
         void'(exp_q.pop_front());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
